cdb_rr_arbiter: RTL and testbench

Fair arbiter that shares the N-wide common data bus between all writeback requesters (ALU, MULT and load FUs). Each requester gets a one-entry holding register with a valid/ready handshake. N winners per cycle are picked by rotating priority with starvation aging, and the broadcast is registered toward ROB, RS and PRF. It replaces fixed-priority writeback selection, so no FU can be starved indefinitely.

---
 rtl/cdb_rr_arbiter_pkg.sv | 25 ++
 rtl/cdb_rr_arbiter_rr_multi_sel.sv | 74 +++++++
 rtl/cdb_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_cdb_rr_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_rr_arbiter_pkg.sv
// Shared definitions for the common data bus (CDB) writeback path.
//   CDB_REQ_PACKET : one writeback result {robn, dest_prn, value, take_branch}
//   CDB_SZ         : number of CDB ports (grants per cycle)
//   CDB_AGE_MAX    : wait age at which a held result is treated as starving
package sys_defs;

   localparam int ROBN_W = 5;   // 32-entry ROB
   localparam int PRN_W  = 6;   // 64 physical registers
   localparam int DATA_W = 32;

   typedef logic [ROBN_W-1:0] ROBN;
   typedef logic [PRN_W-1:0]  PRN;
   typedef logic [DATA_W-1:0] DATA;

   typedef struct packed {
      ROBN  robn;
      PRN   dest_prn;
      DATA  value;
      logic take_branch;
   } CDB_REQ_PACKET;

   localparam int CDB_SZ      = 2;
   localparam int CDB_AGE_MAX = 7;

endpackage

// File: rtl/cdb_rr_arbiter_rr_multi_sel.sv
// Combinational N-grant rotating selector.
//   req       : candidate mask, one bit per requester
//   ptr       : index that has highest priority (search wraps modulo NUM_REQ)
//   slot_free : slots this selector may fill; free slots are filled in order
//   slot_vld  : slot k got a grant
//   slot_oh   : one-hot requester granted in slot k
//   slot_idx  : binary index of the requester granted in slot k
//   gnt       : OR of all slot grants
//   next_ptr  : (last granted index + 1) mod NUM_REQ, or ptr if nothing granted
module rr_multi_sel #(
   parameter int NUM_REQ = 8,
   parameter int N       = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]        req,
   input  logic [IDX_W-1:0]          ptr,
   input  logic [N-1:0]              slot_free,
   output logic [N-1:0]              slot_vld,
   output logic [N-1:0][NUM_REQ-1:0] slot_oh,
   output logic [N-1:0][IDX_W-1:0]   slot_idx,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [IDX_W-1:0]          next_ptr
);

   localparam int SUM_W = IDX_W + 1;

   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0]   rem;
   logic [NUM_REQ-1:0]   oh_rot;
   logic [SUM_W-1:0]     sum;
   logic                 found;

   // The request vector is rotated right by ptr so that a plain
   // lowest-bit-first search implements the rotating priority; each winner
   // is rotated back to its real position.
   always_comb begin
      slot_vld = '0;
      slot_oh  = '0;
      slot_idx = '0;
      gnt      = '0;
      next_ptr = ptr;
      dbl      = {req, req} >> ptr;
      rem      = dbl[NUM_REQ-1:0];
      oh_rot   = '0;
      sum      = '0;
      found    = 1'b0;
      for (int k = 0; k < N; k++) begin
         oh_rot = '0;
         sum    = '0;
         found  = 1'b0;
         if (slot_free[k]) begin
            for (int j = 0; j < NUM_REQ; j++) begin
               if (!found && rem[j]) begin
                  found     = 1'b1;
                  oh_rot[j] = 1'b1;
                  sum       = SUM_W'(ptr) + SUM_W'(j);
               end
            end
         end
         if (found) begin
            rem = rem & ~oh_rot;
            if (sum >= SUM_W'(NUM_REQ))
               sum = sum - SUM_W'(NUM_REQ);
            dbl         = {oh_rot, oh_rot} << ptr;
            slot_vld[k] = 1'b1;
            slot_oh[k]  = dbl[2*NUM_REQ-1:NUM_REQ];
            slot_idx[k] = sum[IDX_W-1:0];
            gnt         = gnt | dbl[2*NUM_REQ-1:NUM_REQ];
            next_ptr    = (sum == SUM_W'(NUM_REQ-1)) ? '0 : IDX_W'(sum + 1'b1);
         end
      end
   end

endmodule

// File: rtl/cdb_rr_arbiter.sv
// CDB writeback arbiter: one holding entry per requester, N grants per cycle,
// starving entries first (ascending index), then round-robin over the rest.
// The broadcast is registered.
//   clock, reset_n : clock, asynchronous active-low reset
//   flush          : squash all held and in-flight results
//   req_valid/pkt  : requester i offers a result
//   req_ready      : holding entry i accepts this cycle
//   cdb_valid/pkt  : registered broadcast per CDB slot
//   cdb_src        : requester index that won each slot
//   starve_hit     : a starving entry was granted in the previous cycle
module cdb_rr_arbiter
   import sys_defs::*;
#(
   parameter int NUM_REQ = 8,
   parameter int N       = CDB_SZ,
   parameter int AGE_MAX = CDB_AGE_MAX,
   parameter int AGE_W   = 3,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic                           flush,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  CDB_REQ_PACKET [NUM_REQ-1:0]    req_pkt,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [N-1:0]                   cdb_valid,
   output CDB_REQ_PACKET [N-1:0]          cdb_pkt,
   output logic [N-1:0][IDX_W-1:0]        cdb_src,
   output logic                           starve_hit
);

   logic [NUM_REQ-1:0]             held_valid_q, held_valid_d;
   CDB_REQ_PACKET [NUM_REQ-1:0]    held_pkt_q, held_pkt_d;
   logic [NUM_REQ-1:0][AGE_W-1:0]  age_q, age_d;
   logic [IDX_W-1:0]               rr_ptr_q, rr_ptr_d;
   logic [N-1:0]                   cdb_valid_q, cdb_valid_d;
   CDB_REQ_PACKET [N-1:0]          cdb_pkt_q, cdb_pkt_d;
   logic [N-1:0][IDX_W-1:0]        cdb_src_q, cdb_src_d;
   logic                           starve_hit_q, starve_hit_d;

   logic [NUM_REQ-1:0]             starving, rr_req, grant;
   logic [N-1:0]                   p1_vld, p2_vld;
   logic [N-1:0][NUM_REQ-1:0]      p1_oh, p2_oh;
   logic [N-1:0][IDX_W-1:0]        p1_idx, p2_idx;
   logic [NUM_REQ-1:0]             p1_gnt, p2_gnt;
   logic [IDX_W-1:0]               p1_next, p2_next;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++)
         starving[i] = held_valid_q[i] && (age_q[i] == AGE_W'(AGE_MAX));
      rr_req = held_valid_q & ~starving;
   end

   // Pass 1: starving entries, fixed ascending priority, all slots available.
   rr_multi_sel #(.NUM_REQ(NUM_REQ), .N(N), .IDX_W(IDX_W)) u_starve_sel (
      .req       (starving),
      .ptr       ('0),
      .slot_free ('1),
      .slot_vld  (p1_vld),
      .slot_oh   (p1_oh),
      .slot_idx  (p1_idx),
      .gnt       (p1_gnt),
      .next_ptr  (p1_next)
   );

   // Pass 2: round-robin over the rest, only into slots pass 1 left empty.
   // Pass 1 fills slots from 0 upward, so the leftover slots are a contiguous top range.
   rr_multi_sel #(.NUM_REQ(NUM_REQ), .N(N), .IDX_W(IDX_W)) u_rr_sel (
      .req       (rr_req),
      .ptr       (rr_ptr_q),
      .slot_free (~p1_vld),
      .slot_vld  (p2_vld),
      .slot_oh   (p2_oh),
      .slot_idx  (p2_idx),
      .gnt       (p2_gnt),
      .next_ptr  (p2_next)
   );

   always_comb begin
      grant = p1_gnt | p2_gnt;
      // A granted entry drains this cycle, so it can be refilled at the same edge.
      req_ready = ~held_valid_q | grant;
      if (flush)
         req_ready = '0;

      held_valid_d = held_valid_q & ~grant;
      held_pkt_d   = held_pkt_q;
      age_d        = age_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            held_valid_d[i] = 1'b1;
            held_pkt_d[i]   = req_pkt[i];
         end
         if (flush || !held_valid_q[i] || grant[i])
            age_d[i] = '0;
         else if (age_q[i] != AGE_W'(AGE_MAX))
            age_d[i] = age_q[i] + 1'b1;
      end
      if (flush)
         held_valid_d = '0;

      for (int k = 0; k < N; k++) begin
         cdb_pkt_d[k] = '0;
         cdb_src_d[k] = p1_vld[k] ? p1_idx[k] : p2_idx[k];
         for (int i = 0; i < NUM_REQ; i++)
            if (p1_oh[k][i] || p2_oh[k][i])
               cdb_pkt_d[k] = held_pkt_q[i];
      end
      cdb_valid_d  = flush ? '0 : (p1_vld | p2_vld);
      rr_ptr_d     = (!flush && (|p2_vld)) ? p2_next : rr_ptr_q;
      starve_hit_d = !flush && (|p1_vld);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         held_valid_q <= '0;
         held_pkt_q   <= '0;
         age_q        <= '0;
         rr_ptr_q     <= '0;
         cdb_valid_q  <= '0;
         cdb_pkt_q    <= '0;
         cdb_src_q    <= '0;
         starve_hit_q <= 1'b0;
      end else begin
         held_valid_q <= held_valid_d;
         held_pkt_q   <= held_pkt_d;
         age_q        <= age_d;
         rr_ptr_q     <= rr_ptr_d;
         cdb_valid_q  <= cdb_valid_d;
         cdb_pkt_q    <= cdb_pkt_d;
         cdb_src_q    <= cdb_src_d;
         starve_hit_q <= starve_hit_d;
      end
   end

   assign cdb_valid  = cdb_valid_q;
   assign cdb_pkt    = cdb_pkt_q;
   assign cdb_src    = cdb_src_q;
   assign starve_hit = starve_hit_q;

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Directed bench for cdb_rr_arbiter. u_dut uses default parameters; u_age
// shares the same stimulus with AGE_MAX=1 so that starvation is reachable.
module tb_cdb_rr_arbiter;
   import sys_defs::*;

   localparam int NUM_REQ = 8;
   localparam int N       = 2;
   localparam int IDX_W   = 3;

   logic                        clock;
   logic                        reset_n;
   logic                        flush;
   logic [NUM_REQ-1:0]          req_valid;
   CDB_REQ_PACKET [NUM_REQ-1:0] req_pkt;

   logic [NUM_REQ-1:0]          req_ready;
   logic [N-1:0]                cdb_valid;
   CDB_REQ_PACKET [N-1:0]       cdb_pkt;
   logic [N-1:0][IDX_W-1:0]     cdb_src;
   logic                        starve_hit;

   logic [NUM_REQ-1:0]          a_req_ready;
   logic [N-1:0]                a_cdb_valid;
   CDB_REQ_PACKET [N-1:0]       a_cdb_pkt;
   logic [N-1:0][IDX_W-1:0]     a_cdb_src;
   logic                        a_starve_hit;

   int checks = 0;
   int errors = 0;

   cdb_rr_arbiter u_dut (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .req_valid(req_valid), .req_pkt(req_pkt), .req_ready(req_ready),
      .cdb_valid(cdb_valid), .cdb_pkt(cdb_pkt), .cdb_src(cdb_src),
      .starve_hit(starve_hit)
   );

   cdb_rr_arbiter #(.AGE_MAX(1), .AGE_W(1)) u_age (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .req_valid(req_valid), .req_pkt(req_pkt), .req_ready(a_req_ready),
      .cdb_valid(a_cdb_valid), .cdb_pkt(a_cdb_pkt), .cdb_src(a_cdb_src),
      .starve_hit(a_starve_hit)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic CDB_REQ_PACKET mk(input int robn, input int prn, input logic [31:0] val);
      CDB_REQ_PACKET p;
      p             = '0;
      p.robn        = ROBN'(robn);
      p.dest_prn    = PRN'(prn);
      p.value       = val;
      p.take_branch = 1'b0;
      return p;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      flush     = 1'b0;
      req_valid = '0;
      req_pkt   = '0;
      tick();
      tick();
      reset_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      flush     = 1'b0;
      req_valid = '0;
      req_pkt   = '0;
      tick();
      checks++;
      if (cdb_valid !== 2'b00 || starve_hit !== 1'b0) begin
         errors++;
         $display("FAIL reset_out: cdb_valid=%b starve_hit=%b, want 00/0", cdb_valid, starve_hit);
      end
      checks++;
      if (cdb_src !== '0 || cdb_pkt !== '0) begin
         errors++;
         $display("FAIL reset_payload: src=%h pkt=%h, want 0", cdb_src, cdb_pkt);
      end
      reset_n = 1'b1;
      #1;
      checks++;
      if (req_ready !== 8'hFF) begin
         errors++;
         $display("FAIL reset_ready: req_ready=%h, want ff", req_ready);
      end
      tick();
      tick();
      checks++;
      if (cdb_valid !== 2'b00 || starve_hit !== 1'b0) begin
         errors++;
         $display("FAIL idle: cdb_valid=%b starve_hit=%b, want 00/0", cdb_valid, starve_hit);
      end
   endtask

   task automatic test_latency();
      do_reset();
      req_valid  = 8'h08;
      req_pkt[3] = mk(5, 12, 32'hDEAD);
      tick();                       // handshake edge
      req_valid = '0;
      checks++;
      if (cdb_valid !== 2'b00) begin
         errors++;
         $display("FAIL latency_early: cdb_valid=%b, want 00", cdb_valid);
      end
      tick();                       // broadcast edge
      checks++;
      if (cdb_valid !== 2'b01 || cdb_src[0] !== 3'd3 || cdb_pkt[0].value !== 32'hDEAD ||
          cdb_pkt[0].robn !== 5'd5 || cdb_pkt[0].dest_prn !== 6'd12) begin
         errors++;
         $display("FAIL latency_bcast: valid=%b src=%0d robn=%0d prn=%0d value=%h, want 01/3/5/12/dead",
                  cdb_valid, cdb_src[0], cdb_pkt[0].robn, cdb_pkt[0].dest_prn, cdb_pkt[0].value);
      end
      tick();
      checks++;
      if (cdb_valid !== 2'b00) begin
         errors++;
         $display("FAIL latency_one_cycle: cdb_valid=%b, want 00", cdb_valid);
      end
   endtask

   task automatic test_round_robin();
      logic [7:0] exp_rdy;
      logic [2:0] exp_src;
      do_reset();
      for (int i = 0; i < NUM_REQ; i++)
         req_pkt[i] = mk(i, i + 16, 32'(i));
      req_valid = '1;
      for (int c = 1; c <= 6; c++) begin
         tick();
         exp_rdy = 8'(8'h03 << (2 * ((c - 1) % 4)));
         checks++;
         if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL rr_ready c%0d: req_ready=%h, want %h", c, req_ready, exp_rdy);
         end
         if (c >= 2) begin
            exp_src = 3'(2 * ((c - 2) % 4));
            checks++;
            if (cdb_valid !== 2'b11 || cdb_src[0] !== exp_src || cdb_src[1] !== exp_src + 3'd1 ||
                cdb_pkt[1].value !== 32'(exp_src + 3'd1)) begin
               errors++;
               $display("FAIL rr_pair c%0d: valid=%b src=(%0d,%0d), want 11 (%0d,%0d)",
                        c, cdb_valid, cdb_src[0], cdb_src[1], exp_src, exp_src + 3'd1);
            end
         end
      end
      req_valid = '0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      req_valid = 8'h08;
      for (int c = 0; c <= 4; c++) begin
         req_pkt[3] = mk(c, 1, 32'(100 + c));
         tick();
         checks++;
         if (req_ready[3] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready c%0d: req_ready[3]=%b, want 1", c, req_ready[3]);
         end
         if (c >= 1) begin
            checks++;
            if (cdb_valid !== 2'b01 || cdb_pkt[0].value !== 32'(100 + c - 1)) begin
               errors++;
               $display("FAIL b2b_value c%0d: valid=%b value=%0d, want 01/%0d",
                        c, cdb_valid, cdb_pkt[0].value, 100 + c - 1);
            end
         end
      end
      req_valid = '0;
      tick();
      checks++;
      if (cdb_valid !== 2'b01 || cdb_pkt[0].value !== 32'd104) begin
         errors++;
         $display("FAIL b2b_last: valid=%b value=%0d, want 01/104", cdb_valid, cdb_pkt[0].value);
      end
   endtask

   task automatic test_starvation();
      logic [2:0] e0;
      // All eight load once; the AGE_MAX=1 instance then sees six starving
      // entries and must serve them lowest index first, two per cycle.
      do_reset();
      for (int i = 0; i < NUM_REQ; i++)
         req_pkt[i] = mk(i, i, 32'(i));
      req_valid = '1;
      tick();
      req_valid = '0;
      for (int c = 0; c < 4; c++) begin
         tick();
         e0 = 3'(2 * c);
         checks++;
         if (a_cdb_valid !== 2'b11 || a_cdb_src[0] !== e0 || a_cdb_src[1] !== e0 + 3'd1 ||
             a_starve_hit !== (c != 0)) begin
            errors++;
            $display("FAIL starve_order c%0d: valid=%b src=(%0d,%0d) hit=%b, want 11 (%0d,%0d) %b",
                     c, a_cdb_valid, a_cdb_src[0], a_cdb_src[1], a_starve_hit, e0, e0 + 3'd1, c != 0);
         end
         checks++;
         if (cdb_valid !== 2'b11 || cdb_src[0] !== e0 || starve_hit !== 1'b0) begin
            errors++;
            $display("FAIL starve_default c%0d: valid=%b src0=%0d hit=%b, want 11/%0d/0",
                     c, cdb_valid, cdb_src[0], starve_hit, e0);
         end
      end
      tick();
      checks++;
      if (a_cdb_valid !== 2'b00 || a_starve_hit !== 1'b0) begin
         errors++;
         $display("FAIL starve_drain: valid=%b hit=%b, want 00/0", a_cdb_valid, a_starve_hit);
      end
      // Entry 5 held while 0 and 1 keep refilling.
      do_reset();
      req_valid = 8'h23;
      tick();
      req_valid = 8'h03;
      tick();                       // out (0,1), 5 waits one cycle
      tick();
      checks++;
      if (a_cdb_valid !== 2'b11 || a_cdb_src[0] !== 3'd5 || a_cdb_src[1] !== 3'd0 || a_starve_hit !== 1'b1) begin
         errors++;
         $display("FAIL starve_e5: valid=%b src=(%0d,%0d) hit=%b, want 11 (5,0) 1",
                  a_cdb_valid, a_cdb_src[0], a_cdb_src[1], a_starve_hit);
      end
      checks++;
      if (cdb_valid !== 2'b11 || cdb_src[0] !== 3'd5 || cdb_src[1] !== 3'd0) begin
         errors++;
         $display("FAIL rr_e5: valid=%b src=(%0d,%0d), want 11 (5,0)", cdb_valid, cdb_src[0], cdb_src[1]);
      end
      req_valid = '0;
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < NUM_REQ; i++)
         req_pkt[i] = mk(i, i, 32'(i));
      req_valid = 8'h01;
      tick();
      req_valid = 8'h14;
      tick();                       // 2,4 held; entry 0 broadcast in flight; rr_ptr=1
      checks++;
      if (cdb_valid !== 2'b01 || cdb_src[0] !== 3'd0) begin
         errors++;
         $display("FAIL flush_pre: valid=%b src0=%0d, want 01/0", cdb_valid, cdb_src[0]);
      end
      flush     = 1'b1;
      req_valid = '1;
      #1;
      checks++;
      if (req_ready !== 8'h00) begin
         errors++;
         $display("FAIL flush_ready: req_ready=%h, want 00", req_ready);
      end
      tick();
      flush     = 1'b0;
      req_valid = '0;
      checks++;
      if (cdb_valid !== 2'b00) begin
         errors++;
         $display("FAIL flush_kill: cdb_valid=%b, want 00", cdb_valid);
      end
      #1;
      checks++;
      if (req_ready !== 8'hFF) begin
         errors++;
         $display("FAIL flush_empty: req_ready=%h, want ff", req_ready);
      end
      tick();
      checks++;
      if (cdb_valid !== 2'b00) begin
         errors++;
         $display("FAIL flush_no_stale: cdb_valid=%b, want 00", cdb_valid);
      end
      // rr_ptr must still be 1: entries 0,1,2 then give (1,2).
      req_valid = 8'h07;
      tick();
      req_valid = '0;
      tick();
      checks++;
      if (cdb_valid !== 2'b11 || cdb_src[0] !== 3'd1 || cdb_src[1] !== 3'd2) begin
         errors++;
         $display("FAIL flush_ptr: valid=%b src=(%0d,%0d), want 11 (1,2)", cdb_valid, cdb_src[0], cdb_src[1]);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < NUM_REQ; i++)
         req_pkt[i] = mk(i, i, 32'(i));
      req_valid = 8'h0F;
      tick();
      req_valid = 8'hF0;
      tick();
      req_valid = '0;
      checks++;
      if (cdb_valid !== 2'b11 || cdb_src[0] !== 3'd0 || cdb_src[1] !== 3'd1) begin
         errors++;
         $display("FAIL areset_pre: valid=%b src=(%0d,%0d), want 11 (0,1)", cdb_valid, cdb_src[0], cdb_src[1]);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (cdb_valid !== 2'b00 || starve_hit !== 1'b0 || cdb_src !== '0) begin
         errors++;
         $display("FAIL areset_now: valid=%b hit=%b src=%h, want 00/0/0", cdb_valid, starve_hit, cdb_src);
      end
      tick();
      reset_n = 1'b1;
      #1;
      checks++;
      if (req_ready !== 8'hFF) begin
         errors++;
         $display("FAIL areset_ready: req_ready=%h, want ff", req_ready);
      end
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if (cdb_valid !== 2'b00) begin
            errors++;
            $display("FAIL areset_stale c%0d: cdb_valid=%b, want 00", c, cdb_valid);
         end
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      flush     = 1'b0;
      req_valid = '0;
      req_pkt   = '0;
      test_reset();
      test_latency();
      test_round_robin();
      test_back_to_back();
      test_starvation();
      test_flush();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
